// File: rtl/aes_feeder.sv
// aes_feeder: gathers up to eight 32-bit host words into one 256-bit block and
// issues it to the AES core with a one-cycle enable. It then waits for the core
// response and streams the 256-bit result back as eight 32-bit words, most
// significant word first. A key-load block (func 2'b00) returns straight to
// collection and produces no output words. An optional WAIT timeout aborts the
// block and pulses err.
//
// Ports:
//   clock, reset       sole clock; asynchronous active-high reset
//   s_valid/s_ready    host word handshake; s_data word, s_func opcode (taken
//                      from the first word only), s_last ends a short block
//   aes_in             request to the core {data[255:0], func[1:0], enable}
//   aes_out            response from the core {data[255:0], ready}
//   m_valid/m_ready    result word handshake; m_data word, m_last on 8th word
//   err                one-cycle pulse when a WAIT timeout aborts the block
//   busy               high while a block is issued, awaited or drained

package aes_feeder_pkg;
    typedef struct packed {
        logic [255:0] data;
        logic [1:0]   func;
        logic         enable;
    } aes_in_type;

    typedef struct packed {
        logic [255:0] data;
        logic         ready;
    } aes_out_type;
endpackage

module aes_feeder
    import aes_feeder_pkg::*;
#(
    parameter int WAIT_MAX = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    input  logic [1:0]  s_func,
    input  logic        s_last,
    output aes_in_type  aes_in,
    input  aes_out_type aes_out,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic        m_last,
    output logic        err,
    output logic        busy
);

    localparam logic [15:0] WAIT_LIM = 16'(WAIT_MAX - 1);

    typedef enum logic [1:0] {COLLECT, ISSUE, WAIT, DRAIN} state_t;

    state_t       state, state_nx;
    logic         armed;
    logic [2:0]   cnt;
    logic [15:0]  wcnt;
    logic [255:0] blk;
    logic [1:0]   func_q;
    logic [255:0] result;
    logic         issue;
    logic         s_take;
    logic         m_take;
    logic         timeout;

    // armed holds s_ready low until the first edge after reset is released
    assign s_take  = (state == COLLECT) && armed && s_valid;
    assign m_take  = (state == DRAIN) && m_ready;
    assign timeout = (WAIT_MAX != 0) && (wcnt == WAIT_LIM);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= COLLECT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        s_ready  = 1'b0;
        issue    = 1'b0;
        m_valid  = 1'b0;
        m_last   = 1'b0;
        err      = 1'b0;
        busy     = 1'b1;
        case (state)
            COLLECT: begin
                busy    = 1'b0;
                s_ready = armed;
                if (s_take && (s_last || cnt == 3'd7)) begin
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                issue    = 1'b1;
                state_nx = WAIT;
            end
            WAIT: begin
                // a response on the timeout cycle still counts as a capture
                if (aes_out.ready) begin
                    state_nx = (func_q == 2'b00) ? COLLECT : DRAIN;
                end else if (timeout) begin
                    err      = 1'b1;
                    state_nx = COLLECT;
                end
            end
            DRAIN: begin
                m_valid = 1'b1;
                m_last  = (cnt == 3'd7);
                if (m_take && cnt == 3'd7) begin
                    state_nx = COLLECT;
                end
            end
            default: state_nx = COLLECT;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            armed  <= 1'b0;
            cnt    <= 3'd0;
            wcnt   <= 16'd0;
            blk    <= '0;
            func_q <= 2'b00;
            result <= '0;
        end else begin
            armed <= 1'b1;
            if (s_take) begin
                // an early s_last wraps the counter so the next block starts at word 0
                cnt <= (s_last || cnt == 3'd7) ? 3'd0 : cnt + 3'd1;
                if (cnt == 3'd0) begin
                    // first word clears the buffer, which zero-fills short blocks
                    blk    <= {s_data, 224'd0};
                    func_q <= s_func;
                end else begin
                    blk[{~cnt, 5'd0} +: 32] <= s_data;
                end
            end
            if (m_take) begin
                cnt <= cnt + 3'd1;
            end
            if (state == WAIT && !aes_out.ready) begin
                wcnt <= wcnt + 16'd1;
            end else begin
                wcnt <= 16'd0;
            end
            if (state == WAIT && aes_out.ready) begin
                result <= aes_out.data;
            end
        end
    end

    assign aes_in = {blk, func_q, issue};
    assign m_data = (state == DRAIN) ? result[{~cnt, 5'd0} +: 32] : 32'd0;

endmodule
